// File: rtl/lcd_dma_pkg.sv
// Shared types and widths for the LCD frame-fetch DMA scheduler.
package lcd_dma_pkg;
  localparam int ADDR_W = 29;
  localparam int FB_W   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/lcd_dma_credit_counter.sv
// Tracks words requested from the DMA but not yet landed in the pixel FIFO.
module lcd_dma_credit_counter #(
  parameter int N = 8,
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] INC_N   = W'(N);
  localparam logic [W-1:0] INC_NM1 = W'(N - 1);

  logic [W-1:0] cnt_d, cnt_q;

  // A stray data beat with nothing outstanding is dropped rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && dec)
      cnt_d = cnt_q + INC_NM1;
    else if (inc)
      cnt_d = cnt_q + INC_N;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/lcd_dma_scheduler.sv
// Issues credit-gated DMA bursts to fetch one frame into the LCD pixel FIFO.
module lcd_dma_scheduler
  import lcd_dma_pkg::*;
#(
  parameter int BURST_SIZE = 8,
  parameter int FIFO_DEPTH = 512,
  parameter int FW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] FB_BASE_ADDR,
  input  logic [FB_W-1:0]   FRAME_BURSTS,
  input  logic              FRAME_START,
  input  logic [FW-1:0]     FIFO_FREE,
  input  logic              DMA_READY,
  input  logic              DMA_RD_DATA_VALID,
  output logic [ADDR_W-1:0] DMA_RD_ADDR,
  output logic              DMA_START,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              FRAME_OVERRUN
);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_SIZE / 2);
  localparam logic [FW:0]       BURST_W   = (FW + 1)'(BURST_SIZE);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [FB_W-1:0]   remaining_d, remaining_q;
  logic              dma_start_d, dma_start_q;
  logic              busy_d, busy_q;
  logic              frame_done_d, frame_done_q;
  logic              overrun_d, overrun_q;
  logic [FW-1:0]     outstanding;
  logic              credit_ok;

  lcd_dma_credit_counter #(
    .N (BURST_SIZE),
    .W (FW)
  ) u_credit (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (dma_start_q),
    .dec     (DMA_RD_DATA_VALID),
    .count   (outstanding)
  );

  // One extra bit so outstanding + BURST_SIZE cannot wrap.
  assign credit_ok = {1'b0, FIFO_FREE} >= ({1'b0, outstanding} + BURST_W);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    dma_start_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = FRAME_START && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          addr_d      = FB_BASE_ADDR;
          remaining_d = FRAME_BURSTS;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        // The cycle after a start only does bookkeeping, so starts never abut
        // and the credit check always sees the updated outstanding count.
        if (dma_start_q) begin
          addr_d      = addr_q + ADDR_STEP;
          remaining_d = remaining_q - FB_W'(1);
        end else if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if (DMA_READY && credit_ok) begin
          dma_start_d = 1'b1;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      dma_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      dma_start_q  <= dma_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign DMA_RD_ADDR   = addr_q;
  assign DMA_START     = dma_start_q;
  assign BUSY          = busy_q;
  assign FRAME_DONE    = frame_done_q;
  assign FRAME_OVERRUN = overrun_q;
endmodule

// File: tb/tb_lcd_dma_scheduler.sv
// Directed bench for lcd_dma_scheduler with BURST_SIZE=8, FIFO_DEPTH=512.
module tb_lcd_dma_scheduler;
  localparam int FW = 10;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [28:0] FB_BASE_ADDR;
  logic [19:0] FRAME_BURSTS;
  logic        FRAME_START;
  logic [FW-1:0] FIFO_FREE;
  logic        DMA_READY;
  logic        DMA_RD_DATA_VALID;
  logic [28:0] DMA_RD_ADDR;
  logic        DMA_START;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        FRAME_OVERRUN;

  int vecs = 0;
  int errs = 0;

  lcd_dma_scheduler dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .FB_BASE_ADDR      (FB_BASE_ADDR),
    .FRAME_BURSTS      (FRAME_BURSTS),
    .FRAME_START       (FRAME_START),
    .FIFO_FREE         (FIFO_FREE),
    .DMA_READY         (DMA_READY),
    .DMA_RD_DATA_VALID (DMA_RD_DATA_VALID),
    .DMA_RD_ADDR       (DMA_RD_ADDR),
    .DMA_START         (DMA_START),
    .BUSY              (BUSY),
    .FRAME_DONE        (FRAME_DONE),
    .FRAME_OVERRUN     (FRAME_OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic start_frame(input logic [28:0] base, input logic [19:0] bursts);
    FB_BASE_ADDR = base;
    FRAME_BURSTS = bursts;
    FRAME_START  = 1'b1;
    tick;
    FRAME_START  = 1'b0;
  endtask

  task automatic drain(input int nv, output bit seen);
    DMA_RD_DATA_VALID = 1'b1;
    repeat (nv) tick;
    DMA_RD_DATA_VALID = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (FRAME_DONE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; FB_BASE_ADDR = '0; FRAME_BURSTS = '0; FRAME_START = 1'b0;
    FIFO_FREE = '0; DMA_READY = 1'b0; DMA_RD_DATA_VALID = 1'b0;
    repeat (2) tick;
    vecs++;
    if ({DMA_START, BUSY, FRAME_DONE, FRAME_OVERRUN} !== 4'b0) begin
      errs++; $display("FAIL reset_flags: got %b expected 0000", {DMA_START, BUSY, FRAME_DONE, FRAME_OVERRUN});
    end
    vecs++;
    if (DMA_RD_ADDR !== 29'h0) begin
      errs++; $display("FAIL reset_addr: got %0h expected 0", DMA_RD_ADDR);
    end
    RESET_N = 1'b1;
    repeat (2) tick;
    vecs++;
    if (BUSY !== 1'b0) begin
      errs++; $display("FAIL idle_busy: got %b expected 0", BUSY);
    end
  endtask

  task automatic test_underflow;
    DMA_RD_DATA_VALID = 1'b1;
    repeat (2) tick;
    DMA_RD_DATA_VALID = 1'b0;
    vecs++;
    if (dut.u_credit.count !== 10'd0) begin
      errs++; $display("FAIL underflow: got %0d expected 0", dut.u_credit.count);
    end
  endtask

  task automatic test_frame;
    int n;
    bit prev, seen;
    FIFO_FREE = 10'd512; DMA_READY = 1'b1;
    start_frame(29'h100, 20'd4);
    vecs++;
    if (BUSY !== 1'b1 || DMA_START !== 1'b0) begin
      errs++; $display("FAIL frame_check_entry: got busy=%b start=%b expected busy=1 start=0", BUSY, DMA_START);
    end
    tick;
    vecs++;
    if (DMA_START !== 1'b1) begin
      errs++; $display("FAIL first_start_latency: got %b expected 1", DMA_START);
    end
    n = 0; prev = 1'b0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (DMA_START) begin
        vecs++;
        if (DMA_RD_ADDR !== 29'h100 + 29'(4 * n)) begin
          errs++; $display("FAIL frame_addr%0d: got %0h expected %0h", n, DMA_RD_ADDR, 29'h100 + 29'(4 * n));
        end
        vecs++;
        if (prev) begin
          errs++; $display("FAIL back_to_back: got consecutive starts expected gap");
        end
        n++;
      end
      prev = DMA_START;
      tick;
    end
    vecs++;
    if (n !== 4) begin
      errs++; $display("FAIL frame_burst_count: got %0d expected 4", n);
    end
    vecs++;
    if (dut.u_credit.count !== 10'd32) begin
      errs++; $display("FAIL frame_outstanding: got %0d expected 32", dut.u_credit.count);
    end
    drain(32, seen);
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL frame_done: got none expected pulse");
    end
    vecs++;
    if (BUSY !== 1'b1) begin
      errs++; $display("FAIL done_busy: got %b expected 1", BUSY);
    end
    tick;
    vecs++;
    if (BUSY !== 1'b0 || FRAME_DONE !== 1'b0) begin
      errs++; $display("FAIL done_pulse_width: got busy=%b done=%b expected 0 0", BUSY, FRAME_DONE);
    end
  endtask

  task automatic test_credit;
    int n;
    bit seen;
    FIFO_FREE = 10'd7; DMA_READY = 1'b1;
    start_frame(29'h0, 20'd2);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (DMA_START) n++;
    end
    vecs++;
    if (n !== 0) begin
      errs++; $display("FAIL credit_free7: got %0d starts expected 0", n);
    end
    FIFO_FREE = 10'd8;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (DMA_START) n++;
    end
    vecs++;
    if (n !== 1) begin
      errs++; $display("FAIL credit_free8: got %0d starts expected 1", n);
    end
    DMA_RD_DATA_VALID = 1'b1;
    repeat (5) tick;
    DMA_RD_DATA_VALID = 1'b0;
    vecs++;
    if (dut.u_credit.count !== 10'd3) begin
      errs++; $display("FAIL credit_after_5: got %0d expected 3", dut.u_credit.count);
    end
    FIFO_FREE = 10'd11;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (DMA_START) break;
    end
    vecs++;
    if (DMA_START !== 1'b1 || DMA_RD_ADDR !== 29'h4) begin
      errs++; $display("FAIL credit_second: got start=%b addr=%0h expected 1 4", DMA_START, DMA_RD_ADDR);
    end
    DMA_RD_DATA_VALID = 1'b1;
    tick;
    DMA_RD_DATA_VALID = 1'b0;
    vecs++;
    if (dut.u_credit.count !== 10'd10) begin
      errs++; $display("FAIL credit_simul: got %0d expected 10", dut.u_credit.count);
    end
    drain(10, seen);
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL credit_done: got none expected pulse");
    end
    tick;
  endtask

  task automatic test_overrun;
    int n, ov;
    bit seen;
    FIFO_FREE = 10'd512; DMA_READY = 1'b1;
    start_frame(29'h200, 20'd4);
    FB_BASE_ADDR = 29'h3000; FRAME_BURSTS = 20'd9;
    FRAME_START = 1'b1;
    tick;
    FRAME_START = 1'b0;
    vecs++;
    if (FRAME_OVERRUN !== 1'b1) begin
      errs++; $display("FAIL overrun_pulse: got %b expected 1", FRAME_OVERRUN);
    end
    n = 0; ov = 0;
    for (int c = 0; c < 20; c++) begin
      if (FRAME_OVERRUN) ov++;
      if (DMA_START) begin
        vecs++;
        if (DMA_RD_ADDR !== 29'h200 + 29'(4 * n)) begin
          errs++; $display("FAIL overrun_addr%0d: got %0h expected %0h", n, DMA_RD_ADDR, 29'h200 + 29'(4 * n));
        end
        n++;
      end
      tick;
    end
    vecs++;
    if (n !== 4 || ov !== 1) begin
      errs++; $display("FAIL overrun_seq: got bursts=%0d pulses=%0d expected 4 1", n, ov);
    end
    drain(32, seen);
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL overrun_done: got none expected pulse");
    end
    tick;
  endtask

  task automatic test_zero_burst;
    int n, cyc;
    FIFO_FREE = 10'd512; DMA_READY = 1'b1;
    start_frame(29'h55, 20'd0);
    n = 0; cyc = 99;
    for (int c = 0; c < 5; c++) begin
      if (DMA_START) n++;
      if (FRAME_DONE) begin
        cyc = c + 1;
        break;
      end
      tick;
    end
    vecs++;
    if (n !== 0 || cyc > 3) begin
      errs++; $display("FAIL zero_burst: got starts=%0d done_cycle=%0d expected 0 <=3", n, cyc);
    end
    FRAME_START = 1'b1;
    tick;
    FRAME_START = 1'b0;
    vecs++;
    if (FRAME_OVERRUN !== 1'b1 || BUSY !== 1'b0) begin
      errs++; $display("FAIL done_overrun: got ov=%b busy=%b expected 1 0", FRAME_OVERRUN, BUSY);
    end
    tick;
    vecs++;
    if (BUSY !== 1'b0 || FRAME_OVERRUN !== 1'b0) begin
      errs++; $display("FAIL done_overrun_ignored: got busy=%b ov=%b expected 0 0", BUSY, FRAME_OVERRUN);
    end
  endtask

  task automatic test_wrap;
    int n;
    bit prev, seen;
    logic [28:0] ea;
    FIFO_FREE = 10'd512; DMA_READY = 1'b1;
    start_frame(29'h1FFF_FFFE, 20'd2);
    n = 0; prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (DMA_START) begin
        ea = (n == 0) ? 29'h1FFF_FFFE : 29'h2;
        vecs++;
        if (DMA_RD_ADDR !== ea || prev) begin
          errs++; $display("FAIL wrap_addr%0d: got %0h prev=%b expected %0h 0", n, DMA_RD_ADDR, prev, ea);
        end
        n++;
      end
      prev = DMA_START;
      tick;
    end
    vecs++;
    if (n !== 2 || DMA_RD_ADDR !== 29'h6) begin
      errs++; $display("FAIL wrap_end: got bursts=%0d addr=%0h expected 2 6", n, DMA_RD_ADDR);
    end
    drain(16, seen);
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL wrap_done: got none expected pulse");
    end
    tick;
  endtask

  task automatic test_reset_midframe;
    int n, bad;
    bit seen;
    FIFO_FREE = 10'd512; DMA_READY = 1'b1;
    start_frame(29'h300, 20'd4);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (DMA_START) n++;
      if (n == 2) break;
    end
    RESET_N = 1'b0;
    #1;
    vecs++;
    if ({DMA_START, BUSY, FRAME_DONE, FRAME_OVERRUN} !== 4'b0 || DMA_RD_ADDR !== 29'h0 ||
        dut.u_credit.count !== 10'd0) begin
      errs++; $display("FAIL async_reset: got flags=%b addr=%0h out=%0d expected 0 0 0",
                       {DMA_START, BUSY, FRAME_DONE, FRAME_OVERRUN}, DMA_RD_ADDR, dut.u_credit.count);
    end
    repeat (2) tick;
    RESET_N = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (DMA_START || FRAME_DONE || BUSY) bad++;
    end
    vecs++;
    if (bad !== 0) begin
      errs++; $display("FAIL post_reset_idle: got %0d active cycles expected 0", bad);
    end
    start_frame(29'h400, 20'd1);
    for (int c = 0; c < 5; c++) begin
      if (DMA_START) break;
      tick;
    end
    vecs++;
    if (DMA_START !== 1'b1 || DMA_RD_ADDR !== 29'h400) begin
      errs++; $display("FAIL restart_addr: got start=%b addr=%0h expected 1 400", DMA_START, DMA_RD_ADDR);
    end
    tick;
    drain(8, seen);
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL restart_done: got none expected pulse");
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_underflow;
    test_frame;
    test_credit;
    test_overrun;
    test_zero_burst;
    test_wrap;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
